// File: rtl/booth_r4_seq_mult_if.sv
// Operand/result bundle for the radix-4 Booth sequential multiplier.
// Handshake: start is honoured only while busy=0 and done=0 (IDLE). The operands are captured on that edge.
// done pulses for one cycle with product valid; product then holds until the next result is written.
interface booth_r4_seq_mult_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 approx_en;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;
    logic [1:0]           state_dbg;

    modport master (
        output start, a, b, approx_en,
        input  busy, done, product, state_dbg
    );

    modport slave (
        input  start, a, b, approx_en,
        output busy, done, product, state_dbg
    );
endinterface

// File: rtl/booth_r4_seq_mult.sv
// Iterative radix-4 Booth signed multiplier, one digit per clock, with optional low-column truncation.
// Define BOOTH_EARLY_TERM_EN to finish as soon as the remaining multiplier digits are all zero.
module booth_r4_seq_mult #(
    parameter int WIDTH    = 8,
    parameter int APPROX_K = 4
) (
    input  logic               clk,
    input  logic               rst,
    booth_r4_seq_mult_if.slave bus
);
    localparam int PW   = 2 * WIDTH;
    localparam int NDIG = WIDTH / 2;
    localparam int IW   = $clog2(NDIG);
    localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic            approx_q, approx_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   product_q, product_d;

    logic [WIDTH:0]  b_ext;
    logic [2:0]      trip;
    logic            neg, two, zero;
    logic [PW-1:0]   a_ext, mag, pp_signed, pp_shift, pp_add, acc_sum;
    logic [PW-1:0]   keep_mask;
    logic            last_digit;

    for (genvar j = 0; j < PW; j++) begin : g_mask
        assign keep_mask[j] = (j >= APPROX_K);
    end

    // Digit i looks at (b[2i+1], b[2i], b[2i-1]); the appended zero supplies b[-1].
    always_comb begin
        b_ext     = {b_q, 1'b0};
        trip      = b_ext[{idx_q, 1'b0} +: 3];
        neg       = trip[2] & (~trip[1] | ~trip[0]);
        two       = (trip[2] & ~trip[1] & ~trip[0]) | (~trip[2] & trip[1] & trip[0]);
        zero      = (trip == 3'b000) || (trip == 3'b111);
        a_ext     = {{WIDTH{a_q[WIDTH-1]}}, a_q};
        mag       = two ? (a_ext << 1) : a_ext;
        pp_signed = zero ? '0 : (neg ? (~mag + PW'(1)) : mag);
        pp_shift  = pp_signed << {idx_q, 1'b0};
        pp_add    = approx_q ? (pp_shift & keep_mask) : pp_shift;
        acc_sum   = acc_q + pp_add;
    end

`ifdef BOOTH_EARLY_TERM_EN
    logic upper_zero, upper_one;

    // Once every multiplier bit above 2i is a copy of the sign, all later digits encode zero.
    always_comb begin
        upper_zero = 1'b1;
        upper_one  = 1'b1;
        for (int j = 0; j < WIDTH; j++) begin
            if (j > 2 * int'(idx_q)) begin
                upper_zero = upper_zero & ~b_q[j];
                upper_one  = upper_one & b_q[j];
            end
        end
        last_digit = (idx_q == LAST_IDX) || upper_zero || upper_one;
    end
`else
    assign last_digit = (idx_q == LAST_IDX);
`endif

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        approx_d  = approx_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        product_d = product_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    approx_d = bus.approx_en;
                    acc_d    = '0;
                    idx_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                acc_d = acc_sum;
                idx_d = idx_q + 1'b1;
                if (last_digit) begin
                    product_d = acc_sum;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            approx_q  <= 1'b0;
            idx_q     <= '0;
            acc_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            approx_q  <= approx_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            product_q <= product_d;
        end
    end

    assign bus.busy      = (state_q == S_RUN);
    assign bus.done      = (state_q == S_DONE);
    assign bus.product   = product_q;
    assign bus.state_dbg = state_q;
endmodule
